// File: rtl/ch0re_mem_arbiter.sv
// Shares one memory port between instruction fetch and data accesses.
// Data wins by default; a starvation counter forces fetch progress; flush drops in-flight fetches.
`timescale 1ns/1ps
module ch0re_mem_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned BE_W        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_flush,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [BE_W-1:0]   i_d_be,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_m_req,
    output logic              o_m_we,
    output logic [BE_W-1:0]   o_m_be,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    input  logic              i_m_gnt,
    input  logic              i_m_rvalid,
    input  logic [DATA_W-1:0] i_m_rdata,
    output logic              o_busy
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;      // 1 = fetch owns the transaction
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic if_elig, pick_i;
    logic gnt_i, gnt_d, rv_i, rv_d;
    logic kill_if;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Arbitration, memory-side drive and next-state selection
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        drop_d    = drop_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        rv_i      = 1'b0;
        rv_d      = 1'b0;
        o_m_req   = 1'b0;
        o_m_we    = 1'b0;
        o_m_be    = '0;
        o_m_addr  = '0;
        o_m_wdata = '0;
        if_elig   = i_if_req && !i_flush;
        pick_i    = if_elig && ((cnt_q == CNT_MAX) || !i_d_req);

        if (rst_n) begin
            if (state_q != IDLE && sel_q && i_flush) begin
                drop_d = 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (i_d_req || if_elig) begin
                        o_m_req = 1'b1;
                        if (pick_i) begin
                            o_m_be   = '1;
                            o_m_addr = i_if_addr;
                        end else begin
                            o_m_we    = i_d_we;
                            o_m_be    = i_d_be;
                            o_m_addr  = i_d_addr;
                            o_m_wdata = i_d_wdata;
                        end
                        sel_d   = pick_i;
                        we_d    = o_m_we;
                        be_d    = o_m_be;
                        addr_d  = o_m_addr;
                        wdata_d = o_m_wdata;
                        if (i_m_gnt) begin
                            gnt_i   = pick_i;
                            gnt_d   = !pick_i;
                            state_d = WAIT;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    o_m_req   = 1'b1;
                    o_m_we    = we_q;
                    o_m_be    = be_q;
                    o_m_addr  = addr_q;
                    o_m_wdata = wdata_q;
                    if (i_m_gnt) begin
                        gnt_i   = sel_q;
                        gnt_d   = !sel_q;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (i_m_rvalid) begin
                        rv_i    = sel_q;
                        rv_d    = !sel_q;
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Count data grants that made a waiting fetch lose
            if (gnt_d && i_if_req) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (gnt_i) begin
                cnt_d = '0;
            end
        end
    end

    assign kill_if     = drop_q || i_flush;
    assign o_if_gnt    = gnt_i && !kill_if;
    assign o_if_rvalid = rv_i && !kill_if;
    assign o_d_gnt     = gnt_d;
    assign o_d_rvalid  = rv_d;
    assign o_if_rdata  = rst_n ? i_m_rdata : '0;
    assign o_d_rdata   = rst_n ? i_m_rdata : '0;
    assign o_busy      = (state_q != IDLE);

endmodule
